cpu_sequencer: RTL and testbench

Multi-cycle control sequencer for the single-cycle-with-clock RISC-V core. Drives the 2-bit `state` bus shared by the instruction memory, register file and data memory: FETCH, DECODE, EXECUTE, WRITEBACK. Owns the program counter. Handles start/stop, data-memory stalls, taken branches, halt requests and end-of-program detection.

---
 rtl/cpu_sequencer.sv | 145 ++++++++++++++
 tb/tb_cpu_sequencer.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_sequencer.sv
// Multi-cycle control sequencer: steps FETCH/DECODE/EXECUTE/WRITEBACK, owns the
// program counter, and handles start/stop, memory stalls, branches and halting.
module cpu_sequencer #(
    parameter int PC_WIDTH  = 10,
    parameter int PROG_END  = 1023,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [PC_WIDTH-1:0]  start_pc,
    input  logic                 stop,
    input  logic                 mem_stall,
    input  logic                 branch_taken,
    input  logic [PC_WIDTH-1:0]  branch_target,
    input  logic                 halt_req,
    output logic [1:0]           state,
    output logic [PC_WIDTH-1:0]  pc,
    output logic                 mem_en,
    output logic                 reg_we,
    output logic                 running,
    output logic                 halted,
    output logic [CNT_WIDTH-1:0] retired
);

    localparam logic [1:0] ST_FETCH     = 2'd0;
    localparam logic [1:0] ST_DECODE    = 2'd1;
    localparam logic [1:0] ST_EXECUTE   = 2'd2;
    localparam logic [1:0] ST_WRITEBACK = 2'd3;

    localparam logic [PC_WIDTH-1:0]  PROG_END_PC = PC_WIDTH'(PROG_END);
    localparam logic [PC_WIDTH-1:0]  PC_ONE      = {{(PC_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [CNT_WIDTH-1:0] CNT_ONE     = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    logic                 rst_rel_r;
    logic                 srst_s;
    logic [1:0]           state_r,   state_s;
    logic [PC_WIDTH-1:0]  pc_r,      pc_s;
    logic                 running_r, running_s;
    logic                 halted_r,  halted_s;
    logic [CNT_WIDTH-1:0] retired_r, retired_s;
    logic                 mem_en_r,  mem_en_s;
    logic                 reg_we_r,  reg_we_s;
    logic                 halt_s;

    // Reset-release flop: assertion is immediate, release takes effect one edge later
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rst_rel_r <= 1'b0;
        end else begin
            rst_rel_r <= 1'b1;
        end
    end

    assign srst_s = ~rst_rel_r;

    // Next-state, program counter and mode computation
    always_comb begin
        state_s   = state_r;
        pc_s      = pc_r;
        running_s = running_r;
        halted_s  = halted_r;
        retired_s = retired_r;
        halt_s    = 1'b0;
        if (stop) begin
            running_s = 1'b0;
            state_s   = ST_FETCH;
        end else if (!running_r) begin
            if (start) begin
                pc_s      = start_pc;
                running_s = 1'b1;
                halted_s  = 1'b0;
                state_s   = ST_FETCH;
            end else begin
                state_s = ST_FETCH;
            end
        end else begin
            case (state_r)
                ST_FETCH:   state_s = ST_DECODE;
                ST_DECODE:  state_s = ST_EXECUTE;
                ST_EXECUTE: begin
                    if (mem_stall) begin
                        state_s = ST_EXECUTE;
                    end else begin
                        state_s = ST_WRITEBACK;
                    end
                end
                ST_WRITEBACK: begin
                    state_s   = ST_FETCH;
                    retired_s = (&retired_r) ? retired_r : retired_r + CNT_ONE;
                    pc_s      = branch_taken ? branch_target : pc_r + PC_ONE;
                    // A taken branch out of the last word keeps the core running
                    halt_s    = halt_req || ((pc_r == PROG_END_PC) && !branch_taken);
                    if (halt_s) begin
                        running_s = 1'b0;
                        halted_s  = 1'b1;
                    end else begin
                        running_s = 1'b1;
                    end
                end
                default: state_s = ST_FETCH;
            endcase
        end
        mem_en_s = running_s && (state_s == ST_EXECUTE);
        reg_we_s = running_s && (state_s == ST_WRITEBACK);
    end

    // Sequencer state registers, strobes registered from their next-state decode
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= ST_FETCH;
            pc_r      <= {PC_WIDTH{1'b0}};
            running_r <= 1'b0;
            halted_r  <= 1'b0;
            retired_r <= {CNT_WIDTH{1'b0}};
            mem_en_r  <= 1'b0;
            reg_we_r  <= 1'b0;
        end else if (srst_s) begin
            state_r   <= ST_FETCH;
            pc_r      <= {PC_WIDTH{1'b0}};
            running_r <= 1'b0;
            halted_r  <= 1'b0;
            retired_r <= {CNT_WIDTH{1'b0}};
            mem_en_r  <= 1'b0;
            reg_we_r  <= 1'b0;
        end else begin
            state_r   <= state_s;
            pc_r      <= pc_s;
            running_r <= running_s;
            halted_r  <= halted_s;
            retired_r <= retired_s;
            mem_en_r  <= mem_en_s;
            reg_we_r  <= reg_we_s;
        end
    end

    assign state   = state_r;
    assign pc      = pc_r;
    assign running = running_r;
    assign halted  = halted_r;
    assign retired = retired_r;
    assign mem_en  = mem_en_r;
    assign reg_we  = reg_we_r;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Directed bench for cpu_sequencer: a default instance plus one with PROG_END=1022
// and a 3-bit retire counter for the branch-at-end and saturation cases.
module tb_cpu_sequencer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [9:0] start_pc = 10'd0;
    logic       stop = 1'b0;
    logic       mem_stall = 1'b0;
    logic       branch_taken = 1'b0;
    logic [9:0] branch_target = 10'd0;
    logic       halt_req = 1'b0;

    logic [1:0]  state_a, state_b;
    logic [9:0]  pc_a, pc_b;
    logic        mem_en_a, mem_en_b, reg_we_a, reg_we_b;
    logic        running_a, running_b, halted_a, halted_b;
    logic [15:0] retired_a;
    logic [2:0]  retired_b;

    int vec = 0;
    int err = 0;

    cpu_sequencer dut_a (
        .clk(clk), .rst_n(rst_n), .start(start), .start_pc(start_pc), .stop(stop),
        .mem_stall(mem_stall), .branch_taken(branch_taken), .branch_target(branch_target),
        .halt_req(halt_req), .state(state_a), .pc(pc_a), .mem_en(mem_en_a),
        .reg_we(reg_we_a), .running(running_a), .halted(halted_a), .retired(retired_a)
    );

    cpu_sequencer #(.PC_WIDTH(10), .PROG_END(1022), .CNT_WIDTH(3)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start), .start_pc(start_pc), .stop(stop),
        .mem_stall(mem_stall), .branch_taken(branch_taken), .branch_target(branch_target),
        .halt_req(halt_req), .state(state_b), .pc(pc_b), .mem_en(mem_en_b),
        .reg_we(reg_we_b), .running(running_b), .halted(halted_b), .retired(retired_b)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1 rst_n = 1'b0;
        tick(1);
        rst_n = 1'b1;
        tick(2);
    endtask

    task automatic do_start(input logic [9:0] addr);
        start = 1'b1;
        start_pc = addr;
        tick(1);
        start = 1'b0;
    endtask

    task automatic do_stop();
        stop = 1'b1;
        tick(1);
        stop = 1'b0;
    endtask

    task automatic test_reset();
        #3;
        vec++; if ({state_a, pc_a, mem_en_a, reg_we_a, running_a, halted_a, retired_a} !== 32'd0) begin
            err++; $display("FAIL reset_outputs: got state=%0d pc=%0d mem_en=%0b reg_we=%0b running=%0b halted=%0b retired=%0d, want all 0",
                state_a, pc_a, mem_en_a, reg_we_a, running_a, halted_a, retired_a);
        end
        rst_n = 1'b1;
        tick(3);
        vec++; if (running_a !== 1'b0 || state_a !== 2'd0) begin
            err++; $display("FAIL idle_after_reset: got running=%0b state=%0d, want 0 0", running_a, state_a);
        end
    endtask

    task automatic test_basic_run();
        logic [9:0] exp_pc;
        do_start(10'd0);
        vec++; if (running_a !== 1'b1 || halted_a !== 1'b0 || pc_a !== 10'd0) begin
            err++; $display("FAIL start_entry: got running=%0b halted=%0b pc=%0d, want 1 0 0", running_a, halted_a, pc_a);
        end
        for (int i = 0; i < 12; i++) begin
            vec++; if (state_a !== 2'(i % 4)) begin
                err++; $display("FAIL run_state[%0d]: got %0d want %0d", i, state_a, i % 4);
            end
            vec++; if (reg_we_a !== (i % 4 == 3) || mem_en_a !== (i % 4 == 2)) begin
                err++; $display("FAIL run_strobes[%0d]: got reg_we=%0b mem_en=%0b want %0b %0b",
                    i, reg_we_a, mem_en_a, (i % 4 == 3), (i % 4 == 2));
            end
            if (i % 4 == 0) begin
                exp_pc = 10'(i / 4);
                vec++; if (pc_a !== exp_pc) begin
                    err++; $display("FAIL run_pc[%0d]: got %0d want %0d", i, pc_a, exp_pc);
                end
            end
            tick(1);
        end
        vec++; if (retired_a !== 16'd3 || pc_a !== 10'd3) begin
            err++; $display("FAIL run_retired: got retired=%0d pc=%0d want 3 3", retired_a, pc_a);
        end
        do_stop();
    endtask

    task automatic test_stall();
        do_reset();
        do_start(10'd0);
        tick(2);
        mem_stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            vec++; if (state_a !== 2'd2 || mem_en_a !== 1'b1) begin
                err++; $display("FAIL stall_exec[%0d]: got state=%0d mem_en=%0b want 2 1", k, state_a, mem_en_a);
            end
            tick(1);
        end
        mem_stall = 1'b0;
        vec++; if (state_a !== 2'd2 || mem_en_a !== 1'b1) begin
            err++; $display("FAIL stall_exec_last: got state=%0d mem_en=%0b want 2 1", state_a, mem_en_a);
        end
        tick(1);
        vec++; if (state_a !== 2'd3 || reg_we_a !== 1'b1 || mem_en_a !== 1'b0 || retired_a !== 16'd0) begin
            err++; $display("FAIL stall_wb: got state=%0d reg_we=%0b mem_en=%0b retired=%0d want 3 1 0 0",
                state_a, reg_we_a, mem_en_a, retired_a);
        end
        tick(1);
        vec++; if (state_a !== 2'd0 || retired_a !== 16'd1 || pc_a !== 10'd1) begin
            err++; $display("FAIL stall_retire: got state=%0d retired=%0d pc=%0d want 0 1 1", state_a, retired_a, pc_a);
        end
    endtask

    task automatic test_branch_wrap();
        tick(3);
        branch_taken = 1'b1;
        branch_target = 10'd1022;
        tick(1);
        branch_taken = 1'b0;
        vec++; if (pc_a !== 10'd1022 || state_a !== 2'd0 || running_a !== 1'b1) begin
            err++; $display("FAIL branch_redirect: got pc=%0d state=%0d running=%0b want 1022 0 1", pc_a, state_a, running_a);
        end
        tick(4);
        vec++; if (pc_a !== 10'd1023 || running_a !== 1'b1 || halted_a !== 1'b0) begin
            err++; $display("FAIL seq_to_end: got pc=%0d running=%0b halted=%0b want 1023 1 0", pc_a, running_a, halted_a);
        end
        tick(4);
        vec++; if (pc_a !== 10'd0 || running_a !== 1'b0 || halted_a !== 1'b1 || state_a !== 2'd0 || retired_a !== 16'd4) begin
            err++; $display("FAIL end_halt_wrap: got pc=%0d running=%0b halted=%0b state=%0d retired=%0d want 0 0 1 0 4",
                pc_a, running_a, halted_a, state_a, retired_a);
        end
        tick(1);
        vec++; if (pc_a !== 10'd0 || state_a !== 2'd0 || reg_we_a !== 1'b0) begin
            err++; $display("FAIL halted_hold: got pc=%0d state=%0d reg_we=%0b want 0 0 0", pc_a, state_a, reg_we_a);
        end
        do_start(10'd1022);
        tick(3);
        branch_taken = 1'b1;
        branch_target = 10'd5;
        tick(1);
        branch_taken = 1'b0;
        vec++; if (running_b !== 1'b1 || halted_b !== 1'b0 || pc_b !== 10'd5) begin
            err++; $display("FAIL branch_at_end: got running=%0b halted=%0b pc=%0d want 1 0 5", running_b, halted_b, pc_b);
        end
        do_stop();
    endtask

    task automatic test_halt_req();
        do_reset();
        do_start(10'd4);
        tick(3);
        halt_req = 1'b1;
        tick(1);
        halt_req = 1'b0;
        vec++; if (retired_a !== 16'd1 || pc_a !== 10'd5 || halted_a !== 1'b1 || running_a !== 1'b0) begin
            err++; $display("FAIL halt_req: got retired=%0d pc=%0d halted=%0b running=%0b want 1 5 1 0",
                retired_a, pc_a, halted_a, running_a);
        end
        halt_req = 1'b1;
        tick(2);
        halt_req = 1'b0;
        vec++; if (pc_a !== 10'd5 || state_a !== 2'd0 || retired_a !== 16'd1) begin
            err++; $display("FAIL halt_hold: got pc=%0d state=%0d retired=%0d want 5 0 1", pc_a, state_a, retired_a);
        end
        do_start(10'd9);
        vec++; if (halted_a !== 1'b0 || running_a !== 1'b1 || pc_a !== 10'd9 || state_a !== 2'd0) begin
            err++; $display("FAIL restart: got halted=%0b running=%0b pc=%0d state=%0d want 0 1 9 0",
                halted_a, running_a, pc_a, state_a);
        end
        do_stop();
    endtask

    task automatic test_stop();
        do_reset();
        do_start(10'd0);
        tick(10);
        vec++; if (state_a !== 2'd2 || pc_a !== 10'd2 || mem_en_a !== 1'b1) begin
            err++; $display("FAIL pre_stop: got state=%0d pc=%0d mem_en=%0b want 2 2 1", state_a, pc_a, mem_en_a);
        end
        start = 1'b1;
        start_pc = 10'd40;
        tick(1);
        start = 1'b0;
        vec++; if (state_a !== 2'd3 || pc_a !== 10'd2) begin
            err++; $display("FAIL start_while_running: got state=%0d pc=%0d want 3 2", state_a, pc_a);
        end
        tick(3);
        mem_stall = 1'b1;
        do_stop();
        mem_stall = 1'b0;
        vec++; if (running_a !== 1'b0 || state_a !== 2'd0 || pc_a !== 10'd3 || reg_we_a !== 1'b0 ||
                   mem_en_a !== 1'b0 || retired_a !== 16'd3 || halted_a !== 1'b0) begin
            err++; $display("FAIL stop_exec: got running=%0b state=%0d pc=%0d reg_we=%0b mem_en=%0b retired=%0d halted=%0b want 0 0 3 0 0 3 0",
                running_a, state_a, pc_a, reg_we_a, mem_en_a, retired_a, halted_a);
        end
        start = 1'b1;
        stop = 1'b1;
        start_pc = 10'd7;
        tick(1);
        start = 1'b0;
        stop = 1'b0;
        tick(1);
        vec++; if (running_a !== 1'b0 || pc_a !== 10'd3 || state_a !== 2'd0) begin
            err++; $display("FAIL start_stop_same: got running=%0b pc=%0d state=%0d want 0 3 0", running_a, pc_a, state_a);
        end
    endtask

    task automatic test_saturate();
        do_reset();
        do_start(10'd0);
        tick(36);
        vec++; if (retired_b !== 3'd7 || retired_a !== 16'd9 || pc_b !== 10'd9) begin
            err++; $display("FAIL retire_saturate: got retired_b=%0d retired_a=%0d pc_b=%0d want 7 9 9", retired_b, retired_a, pc_b);
        end
        do_stop();
    endtask

    task automatic test_async_reset();
        do_reset();
        do_start(10'd0);
        tick(7);
        vec++; if (state_a !== 2'd3 || reg_we_a !== 1'b1 || retired_a !== 16'd1) begin
            err++; $display("FAIL pre_async: got state=%0d reg_we=%0b retired=%0d want 3 1 1", state_a, reg_we_a, retired_a);
        end
        #2 rst_n = 1'b0;
        #1;
        vec++; if ({state_a, pc_a, mem_en_a, reg_we_a, running_a, halted_a, retired_a} !== 32'd0) begin
            err++; $display("FAIL async_reset: got state=%0d pc=%0d mem_en=%0b reg_we=%0b running=%0b halted=%0b retired=%0d, want all 0",
                state_a, pc_a, mem_en_a, reg_we_a, running_a, halted_a, retired_a);
        end
        tick(1);
        rst_n = 1'b1;
        tick(2);
        vec++; if (retired_a !== 16'd0 || running_a !== 1'b0) begin
            err++; $display("FAIL post_async: got retired=%0d running=%0b want 0 0", retired_a, running_a);
        end
    endtask

    initial begin
        test_reset();
        test_basic_run();
        test_stall();
        test_branch_wrap();
        test_halt_req();
        test_stop();
        test_saturate();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vec, err);
        $finish;
    end

endmodule
